// File: rtl/tcp_rx_conn_demux_if.sv
// Segment metadata, parser payload stream and tagged output stream between the
// TCP header parser, the receive demultiplexer and the per-connection reorder stage.
interface tcp_rx_conn_demux_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
);
  logic              meta_valid;
  logic              meta_ready;
  logic [31:0]       meta_src_ip;
  logic [15:0]       meta_src_port;
  logic [15:0]       meta_dst_port;
  logic [15:0]       meta_payload_len;

  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;

  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [IDX_W-1:0]  m_axis_tdest;

  // Parser / reorder-stage side
  modport master (
    output meta_valid, meta_src_ip, meta_src_port, meta_dst_port, meta_payload_len,
    input  meta_ready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
    output m_axis_tready
  );

  // Demultiplexer side
  modport slave (
    input  meta_valid, meta_src_ip, meta_src_port, meta_dst_port, meta_payload_len,
    output meta_ready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
    input  m_axis_tready
  );
endinterface

// File: rtl/tcp_rx_conn_demux.sv
// Multi-connection TCP receive demultiplexer: looks up each segment in a connection
// table, forwards matched payload tagged with its entry index, drains the rest.
// Optional per-entry segment counters: define TCP_DEMUX_STATS_EN.
module tcp_rx_conn_demux #(
  parameter int NUM_CONN = 4,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1,
  parameter int DROP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [31:0]       cfg_remote_ip,
  input  logic [15:0]       cfg_remote_port,
  input  logic [15:0]       cfg_local_port,
`ifdef TCP_DEMUX_STATS_EN
  input  logic [IDX_W-1:0]  stat_idx,
  input  logic              stat_clr,
  output logic [31:0]       stat_segs,
`endif
  tcp_rx_conn_demux_if.slave bus,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_FORWARD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  state_t             r_state;
  state_t             w_next;

  logic               r_en    [NUM_CONN];
  logic [31:0]        r_rip   [NUM_CONN];
  logic [15:0]        r_rport [NUM_CONN];
  logic [15:0]        r_lport [NUM_CONN];

  logic [31:0]        r_src_ip;
  logic [15:0]        r_src_port;
  logic [15:0]        r_dst_port;
  logic               r_len_zero;

  logic [IDX_W-1:0]   r_tdest;
  logic [DROP_W-1:0]  r_drop;

  logic               w_meta_acc;
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_meta_ready;
  logic               w_s_tready;
  logic               w_m_tvalid;
  logic               w_fwd_done;
  logic               w_drop_inc;
  logic [DATA_W-1:0]  w_pass_data;

  // Connection table: enables are control state, addresses/ports are plain data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONN; i++) r_en[i] <= 1'b0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CONN; i++)
        if (cfg_idx == IDX_W'(i)) r_en[i] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      for (int i = 0; i < NUM_CONN; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          r_rip[i]   <= cfg_remote_ip;
          r_rport[i] <= cfg_remote_port;
          r_lport[i] <= cfg_local_port;
        end
      end
    end
  end

  // Stage boundary: metadata accept -> lookup registers
  assign w_meta_acc = (r_state == S_IDLE) && bus.meta_valid;

  always_ff @(posedge clk) begin
    if (w_meta_acc) begin
      r_src_ip   <= bus.meta_src_ip;
      r_src_port <= bus.meta_src_port;
      r_dst_port <= bus.meta_dst_port;
      r_len_zero <= (bus.meta_payload_len == 16'd0);
    end
  end

  // Scanning downwards lets the lowest matching index overwrite higher ones
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_CONN - 1; i >= 0; i--) begin
      if (r_en[i] && (r_rip[i] == r_src_ip) && (r_rport[i] == r_src_port) &&
          (r_lport[i] == r_dst_port)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_meta_ready = 1'b0;
    w_s_tready   = 1'b0;
    w_m_tvalid   = 1'b0;
    w_fwd_done   = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_meta_ready = 1'b1;
        if (bus.meta_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (r_len_zero) begin
          w_next     = S_IDLE;
          w_drop_inc = ~w_hit;
        end else if (w_hit) begin
          w_next = S_FORWARD;
        end else begin
          w_next     = S_DROP;
          w_drop_inc = 1'b1;
        end
      end
      S_FORWARD: begin
        w_m_tvalid = bus.s_axis_tvalid;
        w_s_tready = bus.m_axis_tready;
        if (bus.s_axis_tvalid && bus.m_axis_tready && bus.s_axis_tlast) begin
          w_next     = S_IDLE;
          w_fwd_done = 1'b1;
        end
      end
      S_DROP: begin
        w_s_tready = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stage boundary: lookup result -> state, tag and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tdest <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_LOOKUP) && w_hit) r_tdest <= w_hit_idx;
      if (w_drop_inc) r_drop <= sat_inc(r_drop);
    end
  end

  assign w_pass_data       = bus.s_axis_tdata;
  assign bus.meta_ready    = w_meta_ready & ~rst;
  assign bus.s_axis_tready = w_s_tready;
  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.m_axis_tdata  = w_pass_data;
  assign bus.m_axis_tlast  = bus.s_axis_tlast;
  assign bus.m_axis_tdest  = r_tdest;
  assign drop_count        = r_drop;
  assign busy              = (r_state != S_IDLE);

`ifdef TCP_DEMUX_STATS_EN
  logic [31:0] r_stat_segs [NUM_CONN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONN; i++) r_stat_segs[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_CONN; i++) r_stat_segs[i] <= '0;
    end else if (w_fwd_done) begin
      for (int i = 0; i < NUM_CONN; i++)
        if (r_tdest == IDX_W'(i)) r_stat_segs[i] <= r_stat_segs[i] + 32'd1;
    end
  end

  always_comb begin
    stat_segs = '0;
    for (int i = 0; i < NUM_CONN; i++)
      if (stat_idx == IDX_W'(i)) stat_segs = r_stat_segs[i];
  end
`endif

endmodule

// File: tb/tb_tcp_rx_conn_demux.sv
// Scoreboard bench for tcp_rx_conn_demux: expected output beats are queued as
// payload is driven and checked when the demultiplexer hands them downstream.
module tb_tcp_rx_conn_demux;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;
  localparam int DROP_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we, cfg_en;
  logic [IDX_W-1:0] cfg_idx;
  logic [31:0] cfg_remote_ip;
  logic [15:0] cfg_remote_port, cfg_local_port;
  logic [DROP_W-1:0] drop_count;
  logic busy;
`ifdef TCP_DEMUX_STATS_EN
  logic [IDX_W-1:0] stat_idx;
  logic stat_clr;
  logic [31:0] stat_segs;
`endif

  tcp_rx_conn_demux_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  tcp_rx_conn_demux #(.NUM_CONN(4), .DATA_W(DATA_W), .IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_remote_ip(cfg_remote_ip), .cfg_remote_port(cfg_remote_port),
    .cfg_local_port(cfg_local_port),
`ifdef TCP_DEMUX_STATS_EN
    .stat_idx(stat_idx), .stat_clr(stat_clr), .stat_segs(stat_segs),
`endif
    .bus(bus), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_edge = 0;
  int first_edge = -1;
  int mon_beats = 0;
  int stall_ctr = 0;
  bit stall_en = 1'b0;
  int exp_drop = 0;
  logic [IDX_W+DATA_W:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready: optionally stalls beats 2..4 of a segment for two cycles each
  always @(posedge clk) begin
    #1;
    if (stall_en && mon_beats >= 1 && mon_beats <= 3 && stall_ctr < 2) begin
      bus.m_axis_tready = 1'b0;
      stall_ctr++;
    end else begin
      bus.m_axis_tready = 1'b1;
      stall_ctr = 0;
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid) begin
      chk("s_tready_mirror", {63'd0, bus.s_axis_tready}, {63'd0, bus.m_axis_tready});
      if (sb.size() == 0) begin
        chk("unexpected_m_beat", 64'd1, 64'd0);
      end else if (bus.m_axis_tready) begin
        logic [IDX_W+DATA_W:0] e;
        e = sb.pop_front();
        chk("m_beat", {53'd0, bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata}, {53'd0, e});
        mon_beats++;
        if (first_edge < 0) first_edge = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input bit en, input logic [31:0] ip,
                           input logic [15:0] rp, input logic [15:0] lp);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = en;
    cfg_remote_ip = ip; cfg_remote_port = rp; cfg_local_port = lp;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_meta(input logic [31:0] ip, input logic [15:0] sp,
                           input logic [15:0] dp, input logic [15:0] len);
    int n = 0;
    bus.meta_valid = 1'b1; bus.meta_src_ip = ip; bus.meta_src_port = sp;
    bus.meta_dst_port = dp; bus.meta_payload_len = len;
    @(negedge clk);
    while (!bus.meta_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("meta_ready_timeout", 64'd0, 64'd1);
    acc_edge = cyc + 1;
    tick();
    bus.meta_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input bit last);
    int n = 0;
    bus.s_axis_tdata = d; bus.s_axis_tvalid = 1'b1; bus.s_axis_tlast = last;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("s_tready_timeout", 64'd0, 64'd1);
    tick();
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
  endtask

  task automatic send_seg(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                          input int n, input logic [7:0] base, input bit fwd,
                          input logic [IDX_W-1:0] td);
    logic [7:0] d;
    send_meta(ip, sp, dp, 16'(n));
    for (int k = 0; k < n; k++) begin
      d = 8'((k + 1) * 17) ^ base;
      if (fwd) sb.push_back({td, (k == n - 1), d});
      push_beat(d, k == n - 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", 64'd0, 64'd1);
    tick();
  endtask

  function automatic int sat_drop(input int v);
    return (v >= (1 << DROP_W) - 1) ? v : v + 1;
  endfunction

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_remote_ip = '0; cfg_remote_port = '0; cfg_local_port = '0;
    bus.meta_valid = 1'b0; bus.meta_src_ip = '0; bus.meta_src_port = '0;
    bus.meta_dst_port = '0; bus.meta_payload_len = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
`ifdef TCP_DEMUX_STATS_EN
    stat_idx = '0; stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("rst_meta_ready", {63'd0, bus.meta_ready}, 64'd0);
    chk("rst_m_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd0);
    chk("rst_tdest", {62'd0, bus.m_axis_tdest}, 64'd0);
    chk("rst_drop", {62'd0, drop_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_meta_ready", {63'd0, bus.meta_ready}, 64'd1);
    chk("idle_s_tready", {63'd0, bus.s_axis_tready}, 64'd0);

    // Basic forward to entry 2 with latency check
    cfg_write(2, 1'b1, 32'h0A000002, 16'd5000, 16'd80);
    first_edge = -1;
    send_seg(32'h0A000002, 16'd5000, 16'd80, 4, 8'h00, 1'b1, 2'd2);
    wait_idle();
    chk("t1_latency", 64'(first_edge - acc_edge), 64'd2);
    chk("t1_drop", {62'd0, drop_count}, 64'(exp_drop));

    // Miss with payload: drained and counted
    cfg_write(2, 1'b0, 32'h0A000002, 16'd5000, 16'd80);
    send_meta(32'h0A000002, 16'd5000, 16'd80, 16'd3);
    @(posedge clk); #2;
    chk("t2_drop_tready", {63'd0, bus.s_axis_tready}, 64'd1);
    chk("t2_drop_busy", {63'd0, busy}, 64'd1);
    tick();
    for (int k = 0; k < 3; k++) push_beat(8'(8'hA0 + k), k == 2);
    exp_drop = sat_drop(exp_drop);
    #1;
    chk("t2_idle_busy", {63'd0, busy}, 64'd0);
    chk("t2_meta_ready", {63'd0, bus.meta_ready}, 64'd1);
    chk("t2_drop", {62'd0, drop_count}, 64'(exp_drop));

    // Two matching entries: lowest index wins
    cfg_write(3, 1'b1, 32'h0A000003, 16'd6000, 16'd443);
    cfg_write(1, 1'b1, 32'h0A000003, 16'd6000, 16'd443);
    send_seg(32'h0A000003, 16'd6000, 16'd443, 2, 8'h5A, 1'b1, 2'd1);
    wait_idle();
    chk("t3_tdest", {62'd0, bus.m_axis_tdest}, 64'd1);

    // Zero-length hit: no beats, no drop
    send_meta(32'h0A000003, 16'd6000, 16'd443, 16'd0);
    wait_idle();
    chk("t3_len0_hit_drop", {62'd0, drop_count}, 64'(exp_drop));

    // Backpressure on beats 2..4
    mon_beats = 0; stall_en = 1'b1;
    send_seg(32'h0A000003, 16'd6000, 16'd443, 6, 8'hC3, 1'b1, 2'd1);
    wait_idle();
    stall_en = 1'b0;
    chk("t4_beat_count", 64'(mon_beats), 64'd6);

    // Disabling the active entry mid-segment
    cfg_write(2, 1'b1, 32'h0A000002, 16'd5000, 16'd80);
    mon_beats = 0;
    fork
      send_seg(32'h0A000002, 16'd5000, 16'd80, 5, 8'h3C, 1'b1, 2'd2);
      begin
        int n = 0;
        while (mon_beats < 2 && n < 100) begin @(negedge clk); n++; end
        tick();
        cfg_write(2, 1'b0, 32'h0A000002, 16'd5000, 16'd80);
      end
    join
    wait_idle();
    chk("t5_beats", 64'(mon_beats), 64'd5);
    send_seg(32'h0A000002, 16'd5000, 16'd80, 2, 8'h77, 1'b0, 2'd0);
    exp_drop = sat_drop(exp_drop);
    wait_idle();
    chk("t5_drop", {62'd0, drop_count}, 64'(exp_drop));

    // Async reset during beat 3 of 8
    cfg_write(0, 1'b1, 32'h0A000009, 16'd7000, 16'd22);
    send_meta(32'h0A000009, 16'd7000, 16'd22, 16'd8);
    for (int k = 0; k < 2; k++) begin
      sb.push_back({2'd0, 1'b0, 8'(8'h90 + k)});
      push_beat(8'(8'h90 + k), 1'b0);
    end
    bus.s_axis_tdata = 8'h92; bus.s_axis_tvalid = 1'b1; bus.s_axis_tlast = 1'b0;
    #1;
    chk("t6_pre_rst_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    bus.s_axis_tvalid = 1'b0;
    sb.delete();
    exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("t6_drop_cleared", {62'd0, drop_count}, 64'd0);
    chk("t6_meta_ready", {63'd0, bus.meta_ready}, 64'd1);
    send_meta(32'h0A000009, 16'd7000, 16'd22, 16'd0);
    wait_idle();
    exp_drop = sat_drop(exp_drop);
    chk("t6_table_empty", {62'd0, drop_count}, 64'(exp_drop));

    // Drop counter saturation
    for (int k = 0; k < 3; k++) begin
      send_meta(32'h0B000000 + k, 16'd1, 16'd2, 16'd0);
      wait_idle();
      exp_drop = sat_drop(exp_drop);
      chk("sat_drop", {62'd0, drop_count}, 64'(exp_drop));
    end

`ifdef TCP_DEMUX_STATS_EN
    cfg_write(0, 1'b1, 32'h0A000009, 16'd7000, 16'd22);
    for (int s = 0; s < 2; s++) begin
      send_seg(32'h0A000009, 16'd7000, 16'd22, 1, 8'(s), 1'b1, 2'd0);
      wait_idle();
    end
    stat_idx = 2'd0;
    #1;
    chk("stat_segs_e0", 64'(stat_segs), 64'd2);
    stat_idx = 2'd1;
    #1;
    chk("stat_segs_e1", 64'(stat_segs), 64'd0);
    stat_idx = 2'd0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr", 64'(stat_segs), 64'd0);
`endif

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
